// File: rtl/boot_rom_bus_if0_pkg.sv
// boot_rom_bus_if0_pkg: shared types and constants for the boot ROM bus adapter
package boot_rom_bus_if0_pkg;
  localparam int ROM_ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int RESP_DEPTH = 2;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = 32'h0;
  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;
  function automatic resp_t mk_resp(input logic err, input logic [DATA_WIDTH-1:0] data);
    return '{err: err, data: err ? ERR_DATA : data};
  endfunction
endpackage

// File: rtl/boot_rom_bus_if0_if.sv
// boot_rom_bus_if0_if: req/gnt/rvalid bus between a master and the boot ROM adapter
interface boot_rom_bus_if0_if #(
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      req;
  logic                      we;
  logic [BUS_ADDR_WIDTH-1:0] addr;
  logic [3:0]                be;
  logic                      gnt;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      err;
  logic                      rready;
  modport master (output req, we, addr, be, rready, input gnt, rvalid, rdata, err);
  modport slave (input req, we, addr, be, rready, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/boot_rom_bus_if0_resp_fifo.sv
// boot_rom_resp_fifo0: 2-entry response FIFO with synchronous clear
module boot_rom_resp_fifo0
  import boot_rom_bus_if0_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  resp_t      din,
  output resp_t      head,
  output logic [1:0] count
);
  resp_t mem [RESP_DEPTH];
  logic  wp, rp;
  // pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (clr) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  // storage is not reset; count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
  assign head = mem[rp];
endmodule

// File: rtl/boot_rom_bus_if0.sv
// boot_rom_bus_if0: bus slave adapter issuing single-cycle boot ROM reads with buffered responses
module boot_rom_bus_if0
  import boot_rom_bus_if0_pkg::*;
#(
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int ROM_WORDS = 2 ** (ADDR_WIDTH - 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  boot_rom_bus_if0_if.slave     bus,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i
);
  logic                  infl_q, infl_err_q, rd_ok, push, pop, fifo_busy;
  logic [1:0]            cnt;
  logic [ADDR_WIDTH-3:0] idx;
  resp_t                 head, cur, out;
  logic                  unused;
  assign unused = ^{bus.be, bus.addr};
  assign idx = bus.addr[ADDR_WIDTH-1:2];
  assign rd_ok = ~bus.we & (32'(idx) < 32'(ROM_WORDS));
  assign fifo_busy = cnt != 2'd0;
  // grant only while the response path can absorb one more word
  assign bus.gnt = rst_n & bus.req & (({1'b0, cnt} + {2'b0, infl_q}) < 3'd2);
  assign rom_en_o = bus.gnt & rd_ok;
  assign rom_addr_o = rom_en_o ? {idx, 2'b00} : '0;
  assign cur = mk_resp(infl_err_q, rom_rdata_i);
  // the in-flight response goes straight out when the FIFO is empty and taken, else it is queued
  assign push = infl_q & (fifo_busy | ~bus.rready);
  assign pop = fifo_busy & bus.rready;
  // present FIFO head first to keep grant order; outputs are zero when idle
  always_comb begin
    out = fifo_busy ? head : infl_q ? cur : '0;
  end
  assign bus.rvalid = infl_q | fifo_busy;
  assign bus.rdata = out.data;
  assign bus.err = out.err;
  // in-flight flag: one cycle after grant, carrying the error classification
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      infl_q     <= 1'b0;
      infl_err_q <= 1'b0;
    end else begin
      infl_q     <= bus.gnt;
      infl_err_q <= ~rd_ok;
    end
  end
  boot_rom_resp_fifo0 u_fifo (
    .clk  (clk),
    .clr  (~rst_n),
    .push (push),
    .pop  (pop),
    .din  (cur),
    .head (head),
    .count(cnt)
  );
endmodule

// File: tb/tb_boot_rom_bus_if0.sv
// tb_boot_rom_bus_if0: scoreboard bench for the boot ROM bus adapter
module tb_boot_rom_bus_if0;
  localparam int AW = 8;
  localparam int RW = 40;
  logic          clk = 0;
  logic          rst_n = 0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_rdata = 0;
  logic [31:0]   rom [RW];
  logic [32:0]   q [$];
  int            checks = 0;
  int            passed = 0;
  boot_rom_bus_if0_if #(.BUS_ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  boot_rom_bus_if0 #(.ADDR_WIDTH(AW), .ROM_WORDS(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .rom_en_o   (rom_en),
    .rom_addr_o (rom_addr),
    .rom_rdata_i(rom_rdata)
  );
  always #5 clk = ~clk;
  // ROM model: word valid the cycle after enable, junk otherwise
  always @(posedge clk) rom_rdata <= rom_en ? rom[rom_addr[AW-1:2]] : $urandom;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [32:0] exp_resp(input logic [31:0] a, input logic w);
    int i = int'(a[AW-1:2]);
    if (w || i >= RW) return {1'b1, 32'h0};
    return {1'b0, rom[i]};
  endfunction
  // monitor: grant rule, response order/hold, ROM enables against the queue of outstanding requests
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("gnt_in_reset", {63'b0, bus.gnt}, 64'd0);
      q.delete();
    end else begin
      chk("gnt", {63'b0, bus.gnt}, {63'b0, bus.req && q.size() < 2});
      chk("rvalid", {63'b0, bus.rvalid}, {63'b0, q.size() != 0});
      if (bus.rvalid && q.size() != 0) begin
        chk("resp", {31'b0, bus.err, bus.rdata}, {31'b0, q[0]});
        if (bus.rready) void'(q.pop_front());
      end else chk("idle_out", {31'b0, bus.err, bus.rdata}, 64'd0);
      chk("rom_en", {63'b0, rom_en},
          {63'b0, bus.req && bus.gnt && !bus.we && int'(bus.addr[AW-1:2]) < RW});
      chk("rom_addr", {56'b0, rom_addr}, rom_en ? {56'b0, bus.addr[AW-1:2], 2'b00} : 64'd0);
      if (bus.req && bus.gnt) q.push_back(exp_resp(bus.addr, bus.we));
    end
  end
  task automatic issue(input logic [31:0] a, input logic w);
    bit ok = 0;
    bus.req = 1;
    bus.addr = a;
    bus.we = w;
    bus.be = 4'hF;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = bus.gnt;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL grant_timeout: addr %h never granted", a);
    end
  endtask
  task automatic idle(input int n);
    bus.req = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    for (int i = 0; i < RW; i++) rom[i] = $urandom;
    bus.req = 1;
    bus.we = 0;
    bus.addr = 0;
    bus.be = 0;
    bus.rready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle(1);
    issue(32'h0, 0);
    issue(32'h4, 0);
    issue(32'h8, 0);
    idle(3);
    bus.rready = 0;
    issue(32'h0, 0);
    issue(32'h4, 0);
    fork
      issue(32'h8, 0);
      begin
        repeat (4) @(posedge clk);
        #1 bus.rready = 1;
      end
    join
    issue(32'hC, 0);
    idle(3);
    issue(32'h10, 1);
    issue(RW * 4, 0);
    issue(32'hFC, 0);
    issue(32'hFFFF_0014, 0);
    idle(3);
    bus.rready = 0;
    issue(32'h0, 0);
    issue(32'h4, 0);
    bus.req = 0;
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    bus.rready = 1;
    issue(32'h18, 0);
    idle(3);
    for (int n = 0; n < 3000; n++) begin
      bus.req = ($urandom % 4) != 0;
      bus.we = ($urandom % 6) == 0;
      bus.addr = {$urandom, 2'b00} ^ 32'($urandom % 4);
      bus.be = 4'($urandom);
      bus.rready = ($urandom % 3) != 0;
      rst_n = ($urandom % 200) != 0;
      @(posedge clk);
      #1;
    end
    rst_n = 1;
    bus.rready = 1;
    idle(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
